// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file write port: ALU/load arbitration plus an x1..x31 scrub.
// Optional refused-request counter enabled by defining REGFILE_WB_STALL_CNT_EN.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_start,
  output logic            clr_busy,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [AW-1:0]   m_rd,
  input  logic [XLEN-1:0] m_data,
`ifdef REGFILE_WB_STALL_CNT_EN
  output logic [15:0]     stall_cnt,
`endif
  output logic            enable,
  output logic [AW-1:0]   rd_data,
  output logic [XLEN-1:0] write_data
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [AW-1:0] FIRST_REG = {{(AW-1){1'b0}}, 1'b1};

  state_t          state;
  logic            ptr_m;
  logic [AW-1:0]   clr_cnt;

  logic            arb_open;
  logic            contention;
  logic            transfer;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Grants are combinational; held low during reset, scrub and on a clr_start cycle.
  assign arb_open   = reset && (state == ARB) && !clr_start;
  assign contention = a_valid && m_valid;
  assign a_ready    = arb_open && a_valid && (!m_valid || !ptr_m);
  assign m_ready    = arb_open && m_valid && (!a_valid || ptr_m);
  assign transfer   = a_ready || m_ready;
  assign win_rd     = a_ready ? a_rd : m_rd;
  assign win_data   = a_ready ? a_data : m_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB;
      ptr_m      <= 1'b0;
      clr_cnt    <= FIRST_REG;
      clr_busy   <= 1'b0;
      enable     <= 1'b0;
      rd_data    <= '0;
      write_data <= '0;
    end else begin
      case (state)
        ARB: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            enable   <= 1'b0;
          end else if (transfer) begin
            if (contention) begin
              ptr_m <= ~ptr_m;
            end
            // Writes to x0 are accepted but never reach the register file.
            enable <= (win_rd != '0);
            if (win_rd != '0) begin
              rd_data    <= win_rd;
              write_data <= win_data;
            end
          end else begin
            enable <= 1'b0;
          end
        end
        CLEAR: begin
          enable     <= 1'b1;
          rd_data    <= clr_cnt;
          write_data <= '0;
          if (&clr_cnt) begin
            clr_cnt  <= FIRST_REG;
            state    <= ARB;
            clr_busy <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + FIRST_REG;
          end
        end
        default: begin
          state    <= ARB;
          clr_busy <= 1'b0;
          enable   <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGFILE_WB_STALL_CNT_EN
  logic refused;

  assign refused = (a_valid && !a_ready) || (m_valid && !m_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (refused && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomized bench for regfile_wb_sched against a cycle-level behavioural model.
// Compile with +define+REGFILE_WB_STALL_CNT_EN to also check stall_cnt.
module tb_regfile_wb_sched;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clr_start = 1'b0;
  logic            a_valid = 1'b0;
  logic            m_valid = 1'b0;
  logic [AW-1:0]   a_rd = '0;
  logic [AW-1:0]   m_rd = '0;
  logic [XLEN-1:0] a_data = '0;
  logic [XLEN-1:0] m_data = '0;
  logic            clr_busy, a_ready, m_ready, enable;
  logic [AW-1:0]   rd_data;
  logic [XLEN-1:0] write_data;
`ifdef REGFILE_WB_STALL_CNT_EN
  logic [15:0]     stall_cnt;
`endif

  regfile_wb_sched #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clr_start(clr_start), .clr_busy(clr_busy),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
`ifdef REGFILE_WB_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .enable(enable), .rd_data(rd_data), .write_data(write_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: scrub progress as a count of registers still to clear, plus who wins a tie.
  int              scrub_left = 0;
  bit              favour_alu = 1'b1;
  bit              exp_en = 1'b0;
  bit              exp_busy = 1'b0;
  logic [AW-1:0]   exp_rd = '0;
  logic [XLEN-1:0] exp_wd = '0;
  int              exp_stall = 0;
  bit              last_ga, last_gm;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkRegistered();
    checkOutput("enable", 32'(enable), 32'(exp_en));
    checkOutput("clr_busy", 32'(clr_busy), 32'(exp_busy));
    if (exp_en) begin
      checkOutput("rd_data", 32'(rd_data), 32'(exp_rd));
      checkOutput("write_data", 32'(write_data), 32'(exp_wd));
    end
`ifdef REGFILE_WB_STALL_CNT_EN
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
`endif
  endtask

  // One clock cycle: check last cycle's registered result, drive inputs, check grants, advance model.
  task automatic applyStimulus(input bit rst, input bit cs,
                               input bit av, input logic [AW-1:0] ard, input logic [XLEN-1:0] adat,
                               input bit mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] mdat);
    bit ga, gm;
    logic [AW-1:0] wrd;
    @(negedge clk);
    checkRegistered();
    reset = rst; clr_start = cs;
    a_valid = av; a_rd = ard; a_data = adat;
    m_valid = mv; m_rd = mrd; m_data = mdat;
    #1;
    if (!rst || scrub_left > 0 || cs) begin
      ga = 1'b0; gm = 1'b0;
    end else if (av && mv) begin
      ga = favour_alu; gm = !favour_alu;
    end else begin
      ga = av; gm = mv;
    end
    checkOutput("a_ready", 32'(a_ready), 32'(ga));
    checkOutput("m_ready", 32'(m_ready), 32'(gm));
    last_ga = ga; last_gm = gm;
    if (!rst) begin
      scrub_left = 0; favour_alu = 1'b1; exp_stall = 0;
      exp_en = 1'b0; exp_busy = 1'b0; exp_rd = '0; exp_wd = '0;
      checkOutput("rst_enable", 32'(enable), 32'd0);
      checkOutput("rst_busy", 32'(clr_busy), 32'd0);
      checkOutput("rst_rd_data", 32'(rd_data), 32'd0);
      checkOutput("rst_write_data", write_data, 32'd0);
    end else begin
      if (((av && !ga) || (mv && !gm)) && exp_stall < 65535) exp_stall++;
      if (scrub_left > 0) begin
        exp_en = 1'b1; exp_rd = AW'(32 - scrub_left); exp_wd = '0;
        scrub_left--;
      end else if (cs) begin
        exp_en = 1'b0; scrub_left = 31;
      end else if (ga || gm) begin
        if (av && mv) favour_alu = !favour_alu;
        wrd = ga ? ard : mrd;
        exp_en = (wrd != '0);
        if (exp_en) begin
          exp_rd = wrd; exp_wd = ga ? adat : mdat;
        end
      end else begin
        exp_en = 1'b0;
      end
      exp_busy = (scrub_left > 0);
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    bit av, mv, cs, rst;
    logic [AW-1:0] ard, mrd;
    logic [XLEN-1:0] adat, mdat;
    int guard;

    // Reset held with both requesters asking.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
    repeat (2) idle();

    // Single ALU write.
    applyStimulus(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b0, '0, '0);
    idle();
    checkOutput("alu_wr_en", 32'(enable), 32'd1);
    checkOutput("alu_wr_rd", 32'(rd_data), 32'd5);
    checkOutput("alu_wr_data", write_data, 32'hDEAD);

    // Contention for four cycles alternates A,M,A,M.
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    idle();
`ifdef REGFILE_WB_STALL_CNT_EN
    checkOutput("stall_after_contention", 32'(stall_cnt), 32'd4);
`endif

    // Load to x0 is accepted but writes nothing.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF);
    idle();
    checkOutput("x0_no_write", 32'(enable), 32'd0);

    // Scrub with the ALU waiting throughout.
    applyStimulus(1'b1, 1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    repeat (33) applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    idle();
    idle();

    // Reset in the middle of a scrub, then a fresh scrub starts at x1.
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    guard = 0;
    while (!(exp_en && exp_rd == 5'd10) && guard < 40) begin
      idle();
      guard++;
    end
    checkOutput("scrub_reached_x10", 32'(guard < 40), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    idle();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    idle();
    idle();
    checkOutput("rescrub_rd1", 32'(rd_data), 32'd1);
    repeat (32) idle();

    // Randomized traffic; a refused request is held stable until granted.
    av = 1'b0; mv = 1'b0; ard = '0; mrd = '0; adat = '0; mdat = '0;
    last_ga = 1'b0; last_gm = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!(av && !last_ga)) begin
        av = ($urandom_range(1) == 1);
        ard = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
        adat = $urandom;
      end
      if (!(mv && !last_gm)) begin
        mv = ($urandom_range(1) == 1);
        mrd = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
        mdat = $urandom;
      end
      cs = ($urandom_range(59) == 0);
      rst = ($urandom_range(499) != 0);
      applyStimulus(rst, cs, av, ard, adat, mv, mrd, mdat);
      if (!rst) begin
        av = 1'b0; mv = 1'b0;
      end
    end
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
